// File: rtl/ibfc_sync.sv
// ibfc_sync: input-buffer frame controller that XY-routes the head flit and forwards the frame.
// Optional sticky protocol-error checking is built when IBFC_ERR_CHK_EN is defined.
module ibfc_sync #(
  parameter int DW    = 32,
  parameter int XW    = 4,
  parameter int YW    = 4,
  parameter int CUR_X = 0,
  parameter int CUR_Y = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  input  logic          in_hof,
  input  logic          in_eof,
  output logic [4:0]    rt_req,
  input  logic          rt_gnt,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic          out_eof,
  output logic          eof,
  input  logic          doa,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_ROUTE, S_XFER, S_DRAIN} state_t;

  localparam logic [XW-1:0] LP_CX = XW'(CUR_X);
  localparam logic [YW-1:0] LP_CY = YW'(CUR_Y);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [4:0]    r_rt_req;
  logic          r_out_vld;
  logic [DW-1:0] r_out_data;
  logic          r_out_eof;
  logic          r_eof;
  logic          r_tail_in;   // tail already captured; stop accepting further flits
  logic          w_in_rdy;
  logic          w_in_hs;
  logic          w_out_hs;

  // Route priority: E, W, N, S, then local port. One-hot [0]S [1]W [2]N [3]E [4]L.
  function automatic logic [4:0] route(input logic [XW-1:0] dx, input logic [YW-1:0] dy);
    logic [4:0] req;
    if (dx > LP_CX)      req = 5'b01000;
    else if (dx < LP_CX) req = 5'b00010;
    else if (dy > LP_CY) req = 5'b00100;
    else if (dy < LP_CY) req = 5'b00001;
    else                 req = 5'b10000;
    return req;
  endfunction

  assign in_rdy   = w_in_rdy & ~rst;
  assign w_in_hs  = in_vld & in_rdy;
  assign w_out_hs = r_out_vld & out_rdy;

  // NOTE: every signal driven here gets a default first so no latch is inferred on unlisted paths.
  always_comb begin
    w_state_nxt = r_state;
    w_in_rdy    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_rdy = 1'b1;
        if (in_vld && in_hof) w_state_nxt = S_ROUTE;
      end
      S_ROUTE: begin
        if (rt_gnt) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        w_in_rdy = (~r_out_vld | out_rdy) & ~r_tail_in;
        if (w_out_hs && r_out_eof) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (doa) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rt_req   <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_eof  <= 1'b0;
      r_eof      <= 1'b0;
      r_tail_in  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_in_hs && in_hof) begin
            r_out_data <= in_data;
            r_out_eof  <= in_eof;
            r_tail_in  <= in_eof;
            r_rt_req   <= route(in_data[XW-1:0], in_data[XW+YW-1:XW]);
          end
        end
        S_ROUTE: begin
          if (rt_gnt) r_out_vld <= 1'b1;
        end
        S_XFER: begin
          if (w_in_hs) begin
            r_out_data <= in_data;
            r_out_eof  <= in_eof;
            r_out_vld  <= 1'b1;
            r_tail_in  <= in_eof;
          end else if (w_out_hs) begin
            r_out_vld <= 1'b0;
            if (r_out_eof) r_eof <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (doa) begin
            r_eof    <= 1'b0;
            r_rt_req <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rt_req   = r_rt_req;
  assign out_vld  = r_out_vld;
  assign out_data = r_out_data;
  assign out_eof  = r_out_eof;
  assign eof      = r_eof;

`ifdef IBFC_ERR_CHK_EN
  logic r_err;

  // Sticky: a head arriving mid-frame, or a stray body flit while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (((r_state == S_XFER) && w_in_hs && in_hof) ||
                 ((r_state == S_IDLE) && in_vld && !in_hof)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ibfc_sync.sv
// Directed self-checking bench for ibfc_sync; router placed at (5,5) so every route direction is reachable.
module tb_ibfc_sync;

  localparam int DW = 32;
`ifdef IBFC_ERR_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          in_hof;
  logic          in_eof;
  logic [4:0]    rt_req;
  logic          rt_gnt;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_eof;
  logic          eof;
  logic          doa;
  logic          err;

  int n_vec = 0;
  int n_err = 0;

  ibfc_sync #(.DW(DW), .XW(4), .YW(4), .CUR_X(5), .CUR_Y(5)) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_hof(in_hof), .in_eof(in_eof),
    .rt_req(rt_req), .rt_gnt(rt_gnt),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_eof(out_eof),
    .eof(eof), .doa(doa), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL rst_in_rdy: got %b expected 0", in_rdy); end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rst_out_vld: got %b expected 0", out_vld); end
    n_vec++; if (rt_req !== 5'b0) begin n_err++; $display("FAIL rst_rt_req: got %b expected 00000", rt_req); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    n_vec++; if ({out_eof, eof, err} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b expected 000", {out_eof, eof, err}); end
    rst = 1'b0;
    #1;
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_idle_rdy: got %b expected 1", in_rdy); end
  endtask

  task automatic test_single_local;
    out_rdy = 1'b1;
    in_vld = 1'b1; in_hof = 1'b1; in_eof = 1'b1; in_data = 32'hABCD_0055;
    tick; // cycle 1
    in_vld = 1'b0; in_hof = 1'b0; in_eof = 1'b0;
    n_vec++; if (rt_req !== 5'b10000) begin n_err++; $display("FAIL single_rt_req: got %b expected 10000", rt_req); end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL single_vld_c1: got %b expected 0", out_vld); end
    rt_gnt = 1'b1;
    tick; // cycle 2
    rt_gnt = 1'b0;
    n_vec++; if ({out_vld, out_eof, eof} !== 3'b110) begin n_err++; $display("FAIL single_c2_flags: got %b expected 110", {out_vld, out_eof, eof}); end
    n_vec++; if (out_data !== 32'hABCD_0055) begin n_err++; $display("FAIL single_data: got %h expected abcd0055", out_data); end
    tick; // cycle 3
    n_vec++; if ({eof, out_vld, in_rdy} !== 3'b100) begin n_err++; $display("FAIL single_c3_drain: got %b expected 100", {eof, out_vld, in_rdy}); end
    tick; // cycle 4
    tick; // cycle 5
    doa = 1'b1;
    n_vec++; if (eof !== 1'b1) begin n_err++; $display("FAIL single_c5_eof: got %b expected 1", eof); end
    tick; // cycle 6
    doa = 1'b0;
    n_vec++; if ({eof, rt_req, in_rdy} !== 7'b0_00000_1) begin n_err++; $display("FAIL single_c6_idle: got %b expected 0000001", {eof, rt_req, in_rdy}); end
  endtask

  task automatic test_multi_east;
    out_rdy = 1'b0;
    in_vld = 1'b1; in_hof = 1'b1; in_eof = 1'b0; in_data = 32'h1111_0057;
    tick;
    in_vld = 1'b0; in_hof = 1'b0;
    n_vec++; if ({rt_req, in_rdy} !== 6'b01000_0) begin n_err++; $display("FAIL multi_route: got %b expected 010000", {rt_req, in_rdy}); end
    rt_gnt = 1'b1;
    tick;
    rt_gnt = 1'b0;
    n_vec++; if (out_data !== 32'h1111_0057 || out_vld !== 1'b1) begin n_err++; $display("FAIL multi_head: got %h/%b expected 11110057/1", out_data, out_vld); end
    in_vld = 1'b1; in_data = 32'h2222_2222; out_rdy = 1'b1;
    #1;
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL multi_body_rdy: got %b expected 1", in_rdy); end
    tick;
    n_vec++; if (out_data !== 32'h2222_2222 || out_vld !== 1'b1) begin n_err++; $display("FAIL multi_body: got %h/%b expected 22222222/1", out_data, out_vld); end
    out_rdy = 1'b0; in_data = 32'h3333_3333; in_eof = 1'b1;
    #1;
    n_vec++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL multi_stall_rdy: got %b expected 0", in_rdy); end
    tick;
    tick;
    n_vec++; if ({out_data, out_eof, eof} !== {32'h2222_2222, 2'b00}) begin n_err++; $display("FAIL multi_stall_hold: got %h/%b%b expected 22222222/00", out_data, out_eof, eof); end
    out_rdy = 1'b1;
    tick;
    in_vld = 1'b0; in_eof = 1'b0;
    n_vec++; if ({out_data, out_eof, eof, in_rdy} !== {32'h3333_3333, 3'b100}) begin n_err++; $display("FAIL multi_tail: got %h/%b%b%b expected 33333333/100", out_data, out_eof, eof, in_rdy); end
    tick;
    n_vec++; if ({eof, out_vld} !== 2'b10) begin n_err++; $display("FAIL multi_drain: got %b expected 10", {eof, out_vld}); end
    doa = 1'b1;
    tick;
    doa = 1'b0;
    n_vec++; if ({eof, in_rdy} !== 2'b01) begin n_err++; $display("FAIL multi_release: got %b expected 01", {eof, in_rdy}); end
  endtask

  task automatic test_gnt_delay;
    out_rdy = 1'b1;
    in_vld = 1'b1; in_hof = 1'b1; in_eof = 1'b1; in_data = 32'h0000_0025;
    tick;
    in_vld = 1'b0; in_hof = 1'b0; in_eof = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if ({rt_req, out_vld, in_rdy} !== 7'b00001_00) begin n_err++; $display("FAIL gnt_wait_%0d: got %b expected 0000100", i, {rt_req, out_vld, in_rdy}); end
      tick;
    end
    rt_gnt = 1'b1;
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL gnt_same_cycle: got %b expected 0", out_vld); end
    tick;
    rt_gnt = 1'b0;
    n_vec++; if ({out_vld, rt_req} !== 6'b1_00001) begin n_err++; $display("FAIL gnt_after: got %b expected 100001", {out_vld, rt_req}); end
    tick;
    n_vec++; if (eof !== 1'b1) begin n_err++; $display("FAIL gnt_drain: got %b expected 1", eof); end
    doa = 1'b1;
    tick;
    doa = 1'b0;
  endtask

  task automatic test_doa_ignore;
    doa = 1'b1;
    tick;
    doa = 1'b0;
    n_vec++; if ({in_rdy, eof, rt_req} !== 7'b1_0_00000) begin n_err++; $display("FAIL doa_idle: got %b expected 1000000", {in_rdy, eof, rt_req}); end
    in_vld = 1'b1; in_hof = 1'b1; in_eof = 1'b0; in_data = 32'h0000_0052;
    tick;
    in_vld = 1'b0; in_hof = 1'b0;
    n_vec++; if (rt_req !== 5'b00010) begin n_err++; $display("FAIL doa_route_w: got %b expected 00010", rt_req); end
    rt_gnt = 1'b1;
    tick;
    rt_gnt = 1'b0;
    out_rdy = 1'b0; doa = 1'b1;
    tick;
    n_vec++; if ({out_vld, eof, out_data} !== {2'b10, 32'h0000_0052}) begin n_err++; $display("FAIL doa_xfer: got %b%b/%h expected 10/00000052", out_vld, eof, out_data); end
    out_rdy = 1'b1; in_vld = 1'b1; in_data = 32'h4444_4444; in_eof = 1'b1;
    tick;
    in_vld = 1'b0; in_eof = 1'b0;
    n_vec++; if (out_data !== 32'h4444_4444) begin n_err++; $display("FAIL doa_tail_load: got %h expected 44444444", out_data); end
    tick; // tail handshake with doa high
    doa = 1'b0;
    n_vec++; if (eof !== 1'b1) begin n_err++; $display("FAIL doa_tail_eof: got %b expected 1", eof); end
    tick;
    n_vec++; if ({eof, in_rdy} !== 2'b10) begin n_err++; $display("FAIL doa_tail_ignored: got %b expected 10", {eof, in_rdy}); end
    doa = 1'b1;
    tick;
    doa = 1'b0;
    n_vec++; if ({eof, in_rdy} !== 2'b01) begin n_err++; $display("FAIL doa_drain_release: got %b expected 01", {eof, in_rdy}); end
    in_vld = 1'b1; in_hof = 1'b1; in_eof = 1'b1; in_data = 32'h0000_0095;
    tick;
    in_vld = 1'b0; in_hof = 1'b0; in_eof = 1'b0;
    n_vec++; if (rt_req !== 5'b00100) begin n_err++; $display("FAIL doa_next_route_n: got %b expected 00100", rt_req); end
  endtask

  task automatic test_reset_mid;
    out_rdy = 1'b0;
    rt_gnt = 1'b1;
    tick;
    rt_gnt = 1'b0;
    n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL midrst_pre_vld: got %b expected 1", out_vld); end
    rst = 1'b1;
    tick;
    n_vec++; if ({in_rdy, out_vld, out_eof, eof, err, rt_req, out_data} !== 42'h0) begin n_err++; $display("FAIL midrst_outputs: got %b%b%b%b%b/%b/%h expected all 0", in_rdy, out_vld, out_eof, eof, err, rt_req, out_data); end
    rst = 1'b0;
    #1;
    n_vec++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL midrst_idle: got %b expected 1", in_rdy); end
    in_vld = 1'b1; in_hof = 1'b1; in_eof = 1'b1; in_data = 32'h0000_0059;
    tick;
    in_vld = 1'b0; in_hof = 1'b0; in_eof = 1'b0;
    n_vec++; if (rt_req !== 5'b01000) begin n_err++; $display("FAIL midrst_new_route: got %b expected 01000", rt_req); end
    rt_gnt = 1'b1; out_rdy = 1'b1;
    tick;
    rt_gnt = 1'b0;
    n_vec++; if ({out_vld, out_data} !== {1'b1, 32'h0000_0059}) begin n_err++; $display("FAIL midrst_new_fwd: got %b/%h expected 1/00000059", out_vld, out_data); end
    tick;
    doa = 1'b1;
    tick;
    doa = 1'b0;
  endtask

  task automatic test_err;
    in_vld = 1'b1; in_hof = 1'b0; in_eof = 1'b0; in_data = 32'hDEAD_BEEF;
    tick;
    in_vld = 1'b0;
    n_vec++; if (err !== EXP_ERR) begin n_err++; $display("FAIL err_set: got %b expected %b", err, EXP_ERR); end
    n_vec++; if ({rt_req, in_rdy} !== 6'b00000_1) begin n_err++; $display("FAIL err_dropped: got %b expected 000001", {rt_req, in_rdy}); end
    tick;
    tick;
    n_vec++; if (err !== EXP_ERR) begin n_err++; $display("FAIL err_sticky: got %b expected %b", err, EXP_ERR); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b expected 0", err); end
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = '0; in_hof = 1'b0; in_eof = 1'b0;
    rt_gnt = 1'b0; out_rdy = 1'b0; doa = 1'b0;
    test_reset;
    test_single_local;
    test_multi_east;
    test_gnt_delay;
    test_doa_ignore;
    test_reset_mid;
    test_err;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
